// File: rtl/aes_dma_pkg.sv
// aes_dma_pkg: shared types, sizes and address helper for the AES block DMA.
package aes_dma_pkg;
  localparam int NUM_WORDS = 4;
  localparam int WORD_BYTES = 4;
  typedef enum logic [2:0] {ST_IDLE, ST_RD, ST_BLK, ST_RES, ST_WR, ST_DONE} dma_state_e;
  function automatic logic [31:0] word_addr(input logic [31:0] base, input logic [2:0] idx);
    return {base[31:2], 2'b00} + 32'(idx) * 32'(WORD_BYTES);
  endfunction
endpackage

// File: rtl/aes_block_dma_if.sv
// aes_block_dma_if: req/gnt/rvalid data-memory bus between initiator (master) and responder (slave).
interface aes_block_dma_if;
  logic        req;
  logic        gnt;
  logic        rvalid;
  logic [31:0] addr;
  logic        we;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        err;
  modport master (output req, addr, we, be, wdata, input gnt, rvalid, rdata, err);
  modport slave  (input req, addr, we, be, wdata, output gnt, rvalid, rdata, err);
endinterface

// File: rtl/aes_dma_txn_ctr.sv
// aes_dma_txn_ctr: per-phase issued/retired transaction counters with issue throttling.
module aes_dma_txn_ctr
  import aes_dma_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       clr_i,
  input  logic       issue_i,
  input  logic       retire_i,
  output logic [2:0] issued_o,
  output logic [2:0] retired_o,
  output logic [2:0] outstanding_o,
  output logic       can_issue_o,
  output logic       phase_done_o
);
  logic [2:0] issued_q, issued_d, retired_q, retired_d;
  always_comb begin
    issued_d  = clr_i ? 3'd0 : issued_q + 3'(issue_i);
    retired_d = clr_i ? 3'd0 : retired_q + 3'(retire_i);
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      issued_q  <= 3'd0;
      retired_q <= 3'd0;
    end else begin
      issued_q  <= issued_d;
      retired_q <= retired_d;
    end
  end
  always_comb begin
    issued_o      = issued_q;
    retired_o     = retired_q;
    outstanding_o = issued_q - retired_q;
    can_issue_o   = (issued_q < 3'(NUM_WORDS)) && (outstanding_o < 3'(MAX_OUTSTANDING));
    phase_done_o  = retired_q == 3'(NUM_WORDS);
  end
endmodule

// File: rtl/aes_block_dma.sv
// aes_block_dma: loads a 4-word AES block, hands it to the core, stores the result back.
// Optional AES_BLOCK_DMA_ERR_EN: bus error responses set err_o and abort the job after draining.
module aes_block_dma
  import aes_dma_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   start_i,
  input  logic [31:0]            src_addr_i,
  input  logic [31:0]            dst_addr_i,
  output logic                   busy_o,
  output logic                   done_o,
  output logic                   err_o,
  output logic [127:0]           block_o,
  output logic                   block_valid_o,
  input  logic                   block_ready_i,
  input  logic [127:0]           result_i,
  input  logic                   result_valid_i,
  output logic                   result_ready_o,
  aes_block_dma_if.master        bus
);
  dma_state_e   state_q, state_d;
  logic [31:0]  src_q, dst_q;
  logic [127:0] block_q, result_q;
  logic         err_q;
  logic [2:0]   issued, retired, outstanding;
  logic         can_issue, phase_done, xfer, accept, clr, drained;
  assign xfer    = (state_q == ST_RD) || (state_q == ST_WR);
  assign accept  = (state_q == ST_IDLE) && start_i;
  assign clr     = accept || ((state_q == ST_RES) && result_valid_i);
  // After an error the phase ends as soon as nothing is in flight, not after all four words.
  assign drained = err_q ? (outstanding == 3'd0) : phase_done;
  aes_dma_txn_ctr #(.MAX_OUTSTANDING(MAX_OUTSTANDING)) u_ctr (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .clr_i        (clr),
    .issue_i      (bus.req && bus.gnt),
    .retire_i     (xfer && bus.rvalid),
    .issued_o     (issued),
    .retired_o    (retired),
    .outstanding_o(outstanding),
    .can_issue_o  (can_issue),
    .phase_done_o (phase_done)
  );
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: state_d = start_i ? ST_RD : ST_IDLE;
      ST_RD:   state_d = drained ? (err_q ? ST_DONE : ST_BLK) : ST_RD;
      ST_BLK:  state_d = block_ready_i ? ST_RES : ST_BLK;
      ST_RES:  state_d = result_valid_i ? ST_WR : ST_RES;
      ST_WR:   state_d = drained ? ST_DONE : ST_WR;
      default: state_d = ST_IDLE;
    endcase
  end
  always_comb begin
    busy_o         = state_q != ST_IDLE;
    done_o         = state_q == ST_DONE;
    block_valid_o  = state_q == ST_BLK;
    result_ready_o = state_q == ST_RES;
    err_o          = err_q;
    block_o        = block_q;
    bus.req        = xfer && can_issue && !err_q;
    bus.we         = state_q == ST_WR;
    bus.be         = 4'hF;
    bus.addr       = word_addr(bus.we ? dst_q : src_q, issued);
    bus.wdata      = result_q[32*(NUM_WORDS-1-int'(issued[1:0])) +: 32];
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      src_q    <= '0;
      dst_q    <= '0;
      block_q  <= '0;
      result_q <= '0;
    end else begin
      if (accept) begin
        src_q <= src_addr_i;
        dst_q <= dst_addr_i;
      end
      if ((state_q == ST_RD) && bus.rvalid)
        block_q[32*(NUM_WORDS-1-int'(retired[1:0])) +: 32] <= bus.rdata;
      if ((state_q == ST_RES) && result_valid_i) result_q <= result_i;
    end
  end
`ifdef AES_BLOCK_DMA_ERR_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)     err_q <= 1'b0;
    else if (accept) err_q <= 1'b0;
    else if (xfer && bus.rvalid && bus.err) err_q <= 1'b1;
  end
`else
  assign err_q = 1'b0;
`endif
endmodule
